// File: rtl/ipb_pkg.sv
// Shared constants and helpers for the instruction prefetch buffer.
package ipb_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

    // Width needed to hold a count ranging over 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ipb_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs.
// The head is kept in a register, so it holds its last value while the FIFO is empty.
module ipb_fifo import ipb_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             do_push, do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && !flush;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
            if (do_push) wr_ptr_next = wr_ptr_reg + PW'(1);
            count_next = count_reg + CW'(do_push) - CW'(do_pop);
            // The new head is the word being written when it lands in the head slot.
            if (count_next != '0) begin
                if (do_push && (wr_ptr_reg == rd_ptr_next))
                    head_next = push_data;
                else
                    head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign count = count_reg;
    assign head  = head_reg;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch front-end: credit-limited sequential fetch, in-order response buffering, redirect flush.
// Optional macro IPB_BYPASS_EN forwards a response straight to the core when the buffer is empty.
module inst_prefetch_buffer import ipb_pkg::*; #(
    parameter int              XLEN     = ipb_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data
);

    localparam int CW = cnt_width(DEPTH);

    logic [XLEN-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0]   rsp_pc_reg, rsp_pc_next;
    logic [XLEN-1:0]   redirect_target;
    logic [CW-1:0]     outstanding_reg, outstanding_next;
    logic [CW-1:0]     drop_reg, drop_next;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic [2*XLEN-1:0] fifo_head;
    logic              req_fire, rsp_accept, fifo_push, fifo_pop;

    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign credit_used     = {1'b0, fifo_count} + {1'b0, outstanding_reg};

    // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign mem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc_reg;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_accept    = mem_rsp_valid && (drop_reg == '0) && !redirect_valid;
    assign fifo_pop      = inst_ready && (fifo_count != '0);

`ifdef IPB_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = rsp_accept && (fifo_count == '0);
    assign inst_valid = (fifo_count != '0) || bypass_hit;
    assign inst_pc    = bypass_hit ? rsp_pc_reg   : fifo_head[2*XLEN-1:XLEN];
    assign inst_data  = bypass_hit ? mem_rsp_data : fifo_head[XLEN-1:0];
    assign fifo_push  = rsp_accept && !(bypass_hit && inst_ready);
`else
    assign inst_valid = (fifo_count != '0);
    assign inst_pc    = fifo_head[2*XLEN-1:XLEN];
    assign inst_data  = fifo_head[XLEN-1:0];
    assign fifo_push  = rsp_accept;
`endif

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        drop_next        = drop_reg;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(mem_rsp_valid);
        if (redirect_valid) begin
            // Everything still in flight belongs to the abandoned path.
            fetch_pc_next = redirect_target;
            rsp_pc_next   = redirect_target;
            drop_next     = outstanding_next;
        end else begin
            if (req_fire)
                fetch_pc_next = fetch_pc_reg + XLEN'(4);
            if (rsp_accept)
                rsp_pc_next = rsp_pc_reg + XLEN'(4);
            else if (mem_rsp_valid && (drop_reg != '0))
                drop_next = drop_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    ipb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({rsp_pc_reg, mem_rsp_data}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: in-order memory model plus an expected instruction stream.
`timescale 1ns/1ps
module tb_inst_prefetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, mem_req_ready, mem_rsp_valid, inst_ready;
    logic [31:0] redirect_pc, mem_rsp_data;
    logic        mem_req_valid, inst_valid;
    logic [31:0] mem_req_addr, inst_pc, inst_data;

    always #5 clk = ~clk;

    inst_prefetch_buffer #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] req_log[$];
    int          checks = 0, errors = 0;
    int          cyc = 0, lat = 1, lat_max = 0;
    int          n_req = 0, n_cons = 0;
    bit          rnd = 0, rdy_req = 1, rdy_inst = 1, do_redir = 0;
    logic [31:0] redir_addr = '0;
    logic [31:0] exp_pc = RESET_PC, exp_req = RESET_PC;
    logic        s_req_valid, s_inst_valid;
    logic [31:0] s_addr, s_pc, s_data;

    // Memory contents; address 0 holds lui x2,0xfffff.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hFFFF_F137;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, update the model, advance to next negedge.
    task automatic step();
        mreq_t e;
        if (rnd) begin
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom();
        end else begin
            mem_req_ready  = rdy_req;
            inst_ready     = rdy_inst;
            redirect_valid = do_redir;
            redirect_pc    = redir_addr;
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (reset) begin
            mq.delete();
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            e = mq.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(e.addr);
        end
        #1;
        s_req_valid  = mem_req_valid;
        s_addr       = mem_req_addr;
        s_inst_valid = inst_valid;
        s_pc         = inst_pc;
        s_data       = inst_data;
        if (reset) begin
            exp_pc  = RESET_PC;
            exp_req = RESET_PC;
        end else begin
            if (redirect_valid)
                check("req_blocked_on_redirect", 32'(mem_req_valid), 32'd0);
            if (inst_valid && inst_ready) begin
                check("inst_pc", inst_pc, exp_pc);
                check("inst_data", inst_data, mem_word(exp_pc));
                exp_pc += 32'd4;
                n_cons++;
            end
            if (mem_req_valid && mem_req_ready) begin
                check("req_addr", mem_req_addr, exp_req);
                exp_req += 32'd4;
                n_req++;
                req_log.push_back(mem_req_addr);
                mq.push_back('{mem_req_addr, cyc + ((lat_max > 0) ? int'($urandom_range(1, lat_max)) : lat)});
                check("credit_limit", 32'(mq.size() <= DEPTH), 32'd1);
            end
            if (redirect_valid) begin
                exp_pc  = redirect_pc & 32'hFFFF_FFFC;
                exp_req = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rnd = 0; do_redir = 0; rdy_req = 1; rdy_inst = 1;
        repeat (2) step();
        reset = 1'b0;
        n_req = 0; n_cons = 0;
        req_log.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int c0;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0; inst_ready = 1'b0;
        @(negedge clk);

        // Reset state
        repeat (3) step();
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);

        // Streaming with 1-cycle memory
        reset = 1'b0;
        step();
        check("first_req_valid", 32'(s_req_valid), 32'd1);
        check("first_req_addr", s_addr, RESET_PC);
        check("first_cycle_no_inst", 32'(s_inst_valid), 32'd0);
        step();
`ifdef IPB_BYPASS_EN
        check("bypass_valid", 32'(s_inst_valid), 32'd1);
        check("bypass_data", s_data, 32'hFFFF_F137);
`else
        check("latency_no_inst", 32'(s_inst_valid), 32'd0);
`endif
        step();
        check("latency_valid", 32'(s_inst_valid), 32'd1);
`ifdef IPB_BYPASS_EN
        check("latency_pc", s_pc, 32'h4);
`else
        check("latency_pc", s_pc, 32'h0);
        check("latency_data", s_data, 32'hFFFF_F137);
`endif
        repeat (10) step();
`ifdef IPB_BYPASS_EN
        check("stream_count", n_cons, 12);
`else
        check("stream_count", n_cons, 11);
`endif

        // Core stall: credit limit
        do_reset();
        rdy_inst = 0;
        repeat (10) step();
        check("stall_req_count", n_req, DEPTH);
        check("stall_req_valid", 32'(s_req_valid), 32'd0);
        check("stall_head_valid", 32'(s_inst_valid), 32'd1);
        check("stall_head_pc", s_pc, 32'h0);
        check("stall_last_addr", req_log[3], 32'hC);
        rdy_inst = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (n_req > DEPTH) found = 1;
        end
        check("resume_found", 32'(found), 32'd1);
        check("resume_addr", req_log[DEPTH], 32'h10);
        repeat (4) step();
        check("drain_count", 32'(n_cons >= 4), 32'd1);

        // Redirect with 3 requests in flight, latency 3
        do_reset();
        lat = 3;
        repeat (3) step();
        check("inflight_reqs", n_req, 3);
        do_redir = 1; redir_addr = 32'h103;
        step();
        do_redir = 0;
        step();
        check("redir_req_valid", 32'(s_req_valid), 32'd1);
        check("redir_req_addr", s_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_inst_valid) found = 1;
        end
        check("redir_inst_found", 32'(found), 32'd1);
        check("redir_inst_pc", s_pc, 32'h100);

        // Redirect coinciding with a pop and a response
        do_reset();
        lat = 1;
        repeat (6) step();
        do_redir = 1; redir_addr = 32'h200;
        step();
`ifdef IPB_BYPASS_EN
        check("pop_at_redirect", 32'(s_inst_valid), 32'd0);
`else
        check("pop_at_redirect", 32'(s_inst_valid), 32'd1);
`endif
        do_redir = 0;
        step();
        check("flushed_after_redirect", 32'(s_inst_valid), 32'd0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_inst_valid) found = 1;
        end
        check("target_found", 32'(found), 32'd1);
        check("target_pc", s_pc, 32'h200);

        // Address wrap
        do_redir = 1; redir_addr = 32'hFFFF_FFFE;
        step();
        req_log.delete();
        do_redir = 0;
        repeat (6) step();
        check("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
        check("wrap_addr1", req_log[1], 32'h0000_0000);

        // Reset with three buffered entries
        do_reset();
        rdy_inst = 0;
        repeat (4) step();
        check("prefill_valid", 32'(s_inst_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("post_rst_inst_valid", 32'(s_inst_valid), 32'd0);
        check("post_rst_req_valid", 32'(s_req_valid), 32'd1);
        check("post_rst_req_addr", s_addr, RESET_PC);

        // Randomized traffic: random latency, backpressure and redirects
        do_reset();
        lat_max = 4;
        rnd = 1;
        repeat (3000) step();
        rnd = 0;
        rdy_req = 1; rdy_inst = 1; do_redir = 0;
        c0 = n_cons;
        repeat (30) step();
        check("random_progress", 32'(n_cons - c0 >= 10), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_buffer.md
Name: inst_prefetch_buffer

Overview:
- Instruction fetch front-end that sits directly upstream of the five-stage core's IF stage.
- Drives sequential word addresses to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched words in a small FIFO and presents {inst_pc, inst_data} to the core with valid/ready.
- Core redirects (branch/jump/exception) flush the buffer and restart fetch at the new PC.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding-plus-buffered instructions (power of two, 2..16)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- XLEN, 32, address and instruction width

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  core requests fetch restart
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  word-aligned fetch address
- mem_rsp_valid  in  1  response valid (in order, no backpressure)
- mem_rsp_data  in  XLEN  fetched instruction word
- inst_valid  out  1  instruction available to core
- inst_ready  in  1  core consumes (low = pipeline stall)
- inst_pc  out  XLEN  PC of presented instruction
- inst_data  out  XLEN  presented instruction

Behaviour:
- Reset (sync, active-high):
  - fetch_pc = RESET_PC; FIFO count, outstanding and drop counters = 0.
  - mem_req_valid = 0, inst_valid = 0, inst_pc = 0, inst_data = 0.
  - mem_req_valid may first assert in the cycle after reset deasserts.
- Credit: mem_req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - mem_req_addr = fetch_pc.
  - On handshake (valid && ready): fetch_pc += 4, outstanding += 1.
  - fetch_pc wraps modulo 2^XLEN.
- Response: each mem_rsp_valid decrements outstanding.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise the word is pushed with its PC; response PC comes from a PC tag queue or is derived from rsp_pc, incremented by 4 per accepted response.
- Output: inst_valid = (count != 0); inst_pc/inst_data come from the FIFO head.
  - Latency: response in cycle N -> inst_valid in cycle N+1.
  - Pop on inst_valid && inst_ready.
  - Push and pop may occur in the same cycle; count is unchanged.
- Full: count + outstanding <= DEPTH by construction, so a push never overflows.
  - Full with inst_ready = 0 holds the head stable indefinitely.
- Empty: inst_valid = 0; inst_pc/inst_data hold their last values (don't-care).
- Redirect (cycle R), priority over everything:
  - A pop in cycle R still counts as consumed; the FIFO is then cleared (count = 0).
  - drop = outstanding_after_R: in-flight requests, including any handshaked in R, minus any response arriving in R, which is itself discarded.
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}; rsp_pc = the same value.
  - mem_req_valid = 0 in cycle R; fetch resumes at R+1.
- Back-to-back redirects: the latest wins; drop accumulates correctly.
- Reset mid-operation: all state is cleared. Responses still in flight from before reset are not the block's responsibility; memory is reset together with this block.

Optional Feature:
- Macro: IPB_BYPASS_EN.
- Defined:
  - When count == 0, drop == 0, no redirect and mem_rsp_valid = 1, the response is forwarded combinationally (inst_valid = 1 in the same cycle N).
  - If inst_ready = 1 it is not written to the FIFO; otherwise it is pushed as normal.
- Undefined: strict one-cycle registered latency; no combinational path from mem_rsp_* to inst_*.

Decomposition:
- Shared package ipb_pkg: XLEN, RESET_PC default, INST_NOP = 32'h0000_0013, pointer/counter width function clog2(DEPTH+1).
- One sub-module, ipb_fifo: a DEPTH×(2·XLEN) synchronous FIFO with push, pop, flush, count, head data.
- Credit/drop/PC logic stays in the top level.

Test Plan:
- Reset, mem_req_ready = 1, 1-cycle memory, inst_ready = 1:
  - Requests go to 0x0, 0x4, 0x8, ...
  - The core sees inst_pc 0x0 with 32'hFFFFF137 (lui x2,0xfffff) one cycle after the response, then consecutive PCs.
- inst_ready = 0 for 10 cycles:
  - Exactly DEPTH = 4 requests are issued (0x0–0xC), then mem_req_valid = 0.
  - The head holds pc 0x0; releasing inst_ready drains 4 in order and fetch resumes at 0x10.
- Memory latency 3 with 3 requests in flight, redirect_pc = 0x103:
  - The 3 late responses are dropped.
  - The next request address is 0x100; the next inst_pc is 0x100.
- Redirect in the same cycle as a pop and a response:
  - The popped instruction counts as consumed; the response is discarded.
  - inst_valid = 0 in R+1; the first new instruction has inst_pc = redirect target.
- Redirect to 0xFFFFFFFC:
  - Addresses 0xFFFFFFFC then 0x00000000 (wrap); PCs are tagged correctly.
- Reset asserted with the FIFO holding 3 entries:
  - Next cycle inst_valid = 0 and count = 0.
  - The first request after reset deasserts is to RESET_PC.
  - With IPB_BYPASS_EN defined: an empty-FIFO response appears on inst_data the same cycle.
